// File: rtl/pipe_stage_skid_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the two-entry skid pipeline register used between the
// pipeline stages (IFID, IDEX, EXMEM, MEMWB).
//   state_e    : occupancy state of one stage register
//   *_DATA_W   : default datapath payload width per stage boundary
//   *_CTRL_W   : default control payload width per stage boundary
//   count_of() : occupancy count (0..2) for a given state
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no entries held
    ST_ONE   = 2'd1,  // main slot only
    ST_FULL  = 2'd2   // main and skid slots
  } state_e;

  // IFID: PC 32 + instruction 32
  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  // IDEX: PC 32 + Rs1 data 32 + Rs2 data 32 + Rd 5 + Rs2 5
  localparam int IDEX_DATA_W  = 106;
  localparam int IDEX_CTRL_W  = 9;
  // EXMEM: ALU result 32 + store data 32 + Rd 5
  localparam int EXMEM_DATA_W = 69;
  localparam int EXMEM_CTRL_W = 5;
  // MEMWB: ALU result 32 + read data 32 + Rd 5; ctrl = {RegWrite, MemtoReg}
  localparam int MEMWB_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 2;

  function automatic logic [1:0] count_of(input state_e s);
    logic [1:0] c;
    case (s)
      ST_EMPTY: c = 2'd0;
      ST_ONE:   c = 2'd1;
      ST_FULL:  c = 2'd2;
      default:  c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_if
// Handshake bundle of one pipeline stage register.
//   upstream   : valid_i, ready_o, data_i, ctrl_i
//   downstream : valid_o, ready_i, data_o, ctrl_o
//   status     : count_o (occupancy 0..2)
// Modports:
//   slave  : the stage register's view
//   master : the surrounding logic's view (drives inputs, observes outputs)
// -----------------------------------------------------------------------------
interface pipe_stage_skid_if #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2
) ();

  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [1:0]        count_o;

  modport slave (
    input  valid_i, data_i, ctrl_i, ready_i,
    output ready_o, valid_o, data_o, ctrl_o, count_o
  );

  modport master (
    output valid_i, data_i, ctrl_i, ready_i,
    input  ready_o, valid_o, data_o, ctrl_o, count_o
  );

endinterface

// File: rtl/pipe_stage_skid_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One storage slot (data, ctrl, valid) of the skid stage register.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   flush_i        : clears valid and ctrl (data may stay stale)
//   we_i           : loads valid_d_i/data_d_i/ctrl_d_i
//   *_q_o          : stored slot contents
// -----------------------------------------------------------------------------
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int CTRL_W = MEMWB_CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              we_i,
  input  logic              valid_d_i,
  input  logic [DATA_W-1:0] data_d_i,
  input  logic [CTRL_W-1:0] ctrl_d_i,
  output logic              valid_q_o,
  output logic [DATA_W-1:0] data_q_o,
  output logic [CTRL_W-1:0] ctrl_q_o
);

  // Slot storage: flush has priority over a load in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q_o <= 1'b0;
      data_q_o  <= {DATA_W{1'b0}};
      ctrl_q_o  <= {CTRL_W{1'b0}};
    end else if (flush_i) begin
      valid_q_o <= 1'b0;
      ctrl_q_o  <= {CTRL_W{1'b0}};
    end else if (we_i) begin
      valid_q_o <= valid_d_i;
      data_q_o  <= data_d_i;
      ctrl_q_o  <= ctrl_d_i;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Two-entry (main + skid) pipeline stage register with valid/ready handshake.
// Full throughput with a registered ready path; the skid slot absorbs the
// entry accepted in the cycle downstream stalls.
//   clk_i   : clock (rising edge)
//   rst_n_i : asynchronous active-low reset
//   start_i : run enable; low freezes the stage and drops valid_o/ready_o
//   flush_i : synchronous flush of both slots (offered input is dropped)
//   bus     : handshake bundle (valid/ready/data/ctrl in and out, count_o)
// -----------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int CTRL_W = MEMWB_CTRL_W
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  flush_i,
  pipe_stage_skid_if.slave      bus
);

  state_e            state_q, state_d;
  logic              accept_s, xfer_s;

  logic              main_we_s, main_valid_d, main_valid_q;
  logic [DATA_W-1:0] main_data_d, main_data_q;
  logic [CTRL_W-1:0] main_ctrl_d, main_ctrl_q;
  logic              skid_we_s, skid_valid_d, skid_valid_q;
  logic [DATA_W-1:0] skid_data_d, skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_d, skid_ctrl_q;

  // ready_o is also gated by reset so nothing is offered acceptance while
  // the stage is held in reset.
  assign bus.ready_o = rst_n_i & start_i & (state_q != ST_FULL);
  assign bus.valid_o = start_i & (state_q != ST_EMPTY);
  assign accept_s    = bus.valid_i & bus.ready_o;
  assign xfer_s      = bus.valid_o & bus.ready_i;

  assign bus.data_o  = main_data_q;
  // A bubble never presents control bits (RegWrite must stay low).
  assign bus.ctrl_o  = main_valid_q ? main_ctrl_q : {CTRL_W{1'b0}};
  assign bus.count_o = count_of(state_q);

  // Occupancy state register; flush forces EMPTY regardless of handshakes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
    end else if (flush_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and slot load selection; start_i low blocks both accept and
  // transfer, so every path falls through to hold.
  always_comb begin
    state_d      = state_q;
    main_we_s    = 1'b0;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_we_s    = 1'b0;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          main_we_s    = 1'b1;
          main_valid_d = 1'b1;
          main_data_d  = bus.data_i;
          main_ctrl_d  = bus.ctrl_i;
          state_d      = ST_ONE;
        end else begin
          state_d      = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && !xfer_s) begin
          skid_we_s    = 1'b1;
          skid_valid_d = 1'b1;
          skid_data_d  = bus.data_i;
          skid_ctrl_d  = bus.ctrl_i;
          state_d      = ST_FULL;
        end else if (!accept_s && xfer_s) begin
          main_we_s    = 1'b1;
          main_valid_d = 1'b0;
          state_d      = ST_EMPTY;
        end else if (accept_s && xfer_s) begin
          main_we_s    = 1'b1;
          main_valid_d = 1'b1;
          main_data_d  = bus.data_i;
          main_ctrl_d  = bus.ctrl_i;
          state_d      = ST_ONE;
        end else begin
          state_d      = ST_ONE;
        end
      end
      ST_FULL: begin
        if (xfer_s) begin
          // Older entry leaves; skid moves forward to keep acceptance order.
          main_we_s    = 1'b1;
          main_valid_d = skid_valid_q;
          main_data_d  = skid_data_q;
          main_ctrl_d  = skid_ctrl_q;
          skid_we_s    = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = ST_ONE;
        end else begin
          state_d      = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .flush_i   (flush_i),
    .we_i      (main_we_s),
    .valid_d_i (main_valid_d),
    .data_d_i  (main_data_d),
    .ctrl_d_i  (main_ctrl_d),
    .valid_q_o (main_valid_q),
    .data_q_o  (main_data_q),
    .ctrl_q_o  (main_ctrl_q)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .flush_i   (flush_i),
    .we_i      (skid_we_s),
    .valid_d_i (skid_valid_d),
    .data_d_i  (skid_data_d),
    .ctrl_d_i  (skid_ctrl_d),
    .valid_q_o (skid_valid_q),
    .data_q_o  (skid_data_q),
    .ctrl_q_o  (skid_ctrl_q)
  );

endmodule
